// File: rtl/fifo64_rd_unpack_if.sv
// ---------------------------------------------------------------------------
// fifo64_rd_unpack_if
//   Bundles the FIFO read port and the 32-bit valid/ready output stream of
//   the entropy FIFO read-side unpacker.
//
//   FIFO side   : fifo_empty (to unpacker), fifo_rd_en (from unpacker),
//                 fifo_dout[63:0] (to unpacker, valid 1 cycle after rd_en)
//   Control     : flush (to unpacker, synchronous abort)
//   Stream side : m_data[31:0], m_valid (from unpacker), m_ready (to unpacker)
//   Status      : words_out[CNT_W-1:0], busy (from unpacker)
//
//   master : the unpacker itself
//   slave  : the environment (FIFO, downstream consumer, control)
// ---------------------------------------------------------------------------
interface fifo64_rd_unpack_if #(
  parameter int CNT_W = 32
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [63:0]      fifo_dout;
  logic             flush;
  logic [31:0]      m_data;
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] words_out;
  logic             busy;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  flush,
    input  m_ready,
    output fifo_rd_en,
    output m_data,
    output m_valid,
    output words_out,
    output busy
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output flush,
    output m_ready,
    input  fifo_rd_en,
    input  m_data,
    input  m_valid,
    input  words_out,
    input  busy
  );
endinterface

// File: rtl/fifo64_rd_unpack.sv
// ---------------------------------------------------------------------------
// fifo64_rd_unpack
//   Read-side consumer of the 64-bit TRNG entropy FIFO. Pops one 64-bit word
//   when the FIFO is non-empty, and emits it as two 32-bit words on a
//   valid/ready stream. No prefetch: a new pop starts only after both halves
//   of the previous word have been accepted (max 2 words per 5 cycles).
//
//   Parameters
//     HI_FIRST : 0 -> emit bits[31:0] then [63:32]; 1 -> [63:32] then [31:0]
//     CNT_W    : width of the words_out handshake counter (>= 2)
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous reset, active-high
//     bus  : fifo64_rd_unpack_if.master
//            fifo_empty/fifo_rd_en/fifo_dout : FIFO read port
//            flush                           : synchronous abort
//            m_data/m_valid/m_ready          : 32-bit output stream
//            words_out                       : completed handshakes (wraps)
//            busy                            : 1 whenever state != IDLE
//
//   All outputs are registered (Moore). flush overrides every transition and
//   discards any held or in-flight word without touching words_out.
// ---------------------------------------------------------------------------
module fifo64_rd_unpack #(
  parameter bit HI_FIRST = 1'b0,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  fifo64_rd_unpack_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_CAPT   = 3'd2,
    S_FIRST  = 3'd3,
    S_SECOND = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_rd_en;
  logic [63:0]      r_hold;
  logic [31:0]      r_data;
  logic             r_valid;
  logic [CNT_W-1:0] r_words;
  logic             r_busy;

  // Half that goes out first for a given 64-bit word.
  function automatic logic [31:0] first_half(input logic [63:0] w);
    if (HI_FIRST) return w[63:32];
    else          return w[31:0];
  endfunction

  // Half that goes out second for a given 64-bit word.
  function automatic logic [31:0] second_half(input logic [63:0] w);
    if (HI_FIRST) return w[31:0];
    else          return w[63:32];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rd_en <= 1'b0;
      r_hold  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_words <= '0;
      r_busy  <= 1'b0;
    end else begin
      // rd_en is only ever high for the single cycle spent in REQ.
      r_rd_en <= 1'b0;

      if (bus.flush) begin
        // A word popped in REQ is still in flight and gets dropped here too;
        // the FIFO has already advanced, so that word is gone for good.
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_hold  <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            // fifo_empty is only looked at here; as sole reader we know it
            // cannot flip back to empty while the pop is in progress.
            if (!bus.fifo_empty) begin
              r_state <= S_REQ;
              r_rd_en <= 1'b1;
              r_busy  <= 1'b1;
            end
          end

          S_REQ: begin
            r_state <= S_CAPT;
          end

          S_CAPT: begin
            // FIFO data is registered, so it is valid now, one cycle after
            // the rd_en pulse. Load the first half straight from it.
            r_hold  <= bus.fifo_dout;
            r_data  <= first_half(bus.fifo_dout);
            r_valid <= 1'b1;
            r_state <= S_FIRST;
          end

          S_FIRST: begin
            if (bus.m_ready) begin
              r_data  <= second_half(r_hold);
              r_words <= r_words + CNT_ONE;
              r_state <= S_SECOND;
            end
          end

          S_SECOND: begin
            if (bus.m_ready) begin
              r_valid <= 1'b0;
              r_words <= r_words + CNT_ONE;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.fifo_rd_en = r_rd_en;
  assign bus.m_data     = r_data;
  assign bus.m_valid    = r_valid;
  assign bus.words_out  = r_words;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_fifo64_rd_unpack.sv
module tb_fifo64_rd_unpack;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance LO: HI_FIRST=0, CNT_W=32. Instance HI: HI_FIRST=1, CNT_W=3.
  fifo64_rd_unpack_if #(.CNT_W(32)) if0 ();
  fifo64_rd_unpack_if #(.CNT_W(3))  if1 ();

  fifo64_rd_unpack #(.HI_FIRST(1'b0), .CNT_W(32)) u_lo (
    .clk (clk),
    .rst (rst),
    .bus (if0.master)
  );

  fifo64_rd_unpack #(.HI_FIRST(1'b1), .CNT_W(3)) u_hi (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  // Simple FIFO models: write side from the stimulus, read side registered.
  logic [63:0] mem0 [0:15];
  logic [63:0] mem1 [0:15];
  int wp0 = 0, wp1 = 0;
  int rp0 = 0, rp1 = 0;
  int rdcnt0 = 0, rdcnt1 = 0;
  int cyc = 0;
  int pulse1 [0:15];

  assign if0.fifo_empty = (wp0 == rp0);
  assign if1.fifo_empty = (wp1 == rp1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if0.fifo_rd_en) begin
      if0.fifo_dout <= mem0[rp0 % 16];
      rp0           <= rp0 + 1;
      rdcnt0        <= rdcnt0 + 1;
    end
    if (if1.fifo_rd_en) begin
      if1.fifo_dout        <= mem1[rp1 % 16];
      rp1                  <= rp1 + 1;
      rdcnt1               <= rdcnt1 + 1;
      pulse1[rdcnt1 % 16]  <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [63:0] w);
    mem0[wp0 % 16] = w;
    wp0 = wp0 + 1;
  endtask

  task automatic push1(input logic [63:0] w);
    mem1[wp1 % 16] = w;
    wp1 = wp1 + 1;
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if ({if0.fifo_rd_en, if0.m_valid, if0.busy} !== 3'b000 || if0.m_data !== 32'h0 ||
        if0.words_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_lo: rd_en=%b valid=%b busy=%b data=%h words=%0d required all 0",
               if0.fifo_rd_en, if0.m_valid, if0.busy, if0.m_data, if0.words_out);
    end
    tests++;
    if ({if1.fifo_rd_en, if1.m_valid, if1.busy} !== 3'b000 || if1.m_data !== 32'h0 ||
        if1.words_out !== 3'h0) begin
      fails++;
      $display("FAIL reset_hi: rd_en=%b valid=%b busy=%b data=%h words=%0d required all 0",
               if1.fifo_rd_en, if1.m_valid, if1.busy, if1.m_data, if1.words_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (rdcnt0 !== 0 || rdcnt1 !== 0 || if0.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_rd: rdcnt0=%0d rdcnt1=%0d busy=%b required 0 0 0",
               rdcnt0, rdcnt1, if0.busy);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_lo_first();
    int rd0;
    rd0 = rdcnt0;
    if0.m_ready = 1'b1;
    push0(64'h0123_4567_89AB_CDEF);
    tick();
    tests++;
    if (if0.fifo_rd_en !== 1'b1 || if0.busy !== 1'b1) begin
      fails++;
      $display("FAIL lo_req: rd_en=%b busy=%b required 1 1", if0.fifo_rd_en, if0.busy);
    end
    tick();
    tests++;
    if (if0.fifo_rd_en !== 1'b0 || if0.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL lo_capt: rd_en=%b valid=%b required 0 0", if0.fifo_rd_en, if0.m_valid);
    end
    tick();
    tests++;
    if (if0.m_valid !== 1'b1 || if0.m_data !== 32'h89AB_CDEF) begin
      fails++;
      $display("FAIL lo_first: valid=%b data=%h required 1 89abcdef", if0.m_valid, if0.m_data);
    end
    tick();
    tests++;
    if (if0.m_valid !== 1'b1 || if0.m_data !== 32'h0123_4567 || if0.words_out !== 32'd1) begin
      fails++;
      $display("FAIL lo_second: valid=%b data=%h words=%0d required 1 01234567 1",
               if0.m_valid, if0.m_data, if0.words_out);
    end
    tick();
    tests++;
    if (if0.m_valid !== 1'b0 || if0.words_out !== 32'd2 || if0.busy !== 1'b0 ||
        rdcnt0 - rd0 !== 1) begin
      fails++;
      $display("FAIL lo_done: valid=%b words=%0d busy=%b pops=%0d required 0 2 0 1",
               if0.m_valid, if0.words_out, if0.busy, rdcnt0 - rd0);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_hi_first();
    if1.m_ready = 1'b1;
    push1(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (if1.m_valid !== 1'b1 || if1.m_data !== 32'h0123_4567) begin
      fails++;
      $display("FAIL hi_first: valid=%b data=%h required 1 01234567", if1.m_valid, if1.m_data);
    end
    tick();
    tests++;
    if (if1.m_valid !== 1'b1 || if1.m_data !== 32'h89AB_CDEF) begin
      fails++;
      $display("FAIL hi_second: valid=%b data=%h required 1 89abcdef", if1.m_valid, if1.m_data);
    end
    tick();
    tests++;
    if (if1.m_valid !== 1'b0 || if1.words_out !== 3'd2 || rdcnt1 !== 1) begin
      fails++;
      $display("FAIL hi_done: valid=%b words=%0d pops=%0d required 0 2 1",
               if1.m_valid, if1.words_out, rdcnt1);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_backpressure();
    int n;
    int rd0;
    rd0 = rdcnt0;
    if0.m_ready = 1'b0;
    push0(64'hDEAD_BEEF_CAFE_F00D);
    n = 0;
    while (!if0.m_valid && n < 20) begin tick(); n++; end
    tests++;
    if (if0.m_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_wait_valid: valid=%b required 1 within 20 cycles", if0.m_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (if0.m_valid !== 1'b1 || if0.m_data !== 32'hCAFE_F00D || if0.fifo_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h rd_en=%b required 1 cafef00d 0",
                 i, if0.m_valid, if0.m_data, if0.fifo_rd_en);
      end
    end
    if0.m_ready = 1'b1;
    tick();
    tests++;
    if (if0.m_valid !== 1'b1 || if0.m_data !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL bp_second: valid=%b data=%h required 1 deadbeef", if0.m_valid, if0.m_data);
    end
    tick();
    tests++;
    if (if0.m_valid !== 1'b0 || if0.words_out !== 32'd4 || rdcnt0 - rd0 !== 1) begin
      fails++;
      $display("FAIL bp_done: valid=%b words=%0d pops=%0d required 0 4 1",
               if0.m_valid, if0.words_out, rdcnt0 - rd0);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [63:0] words [0:3];
    logic [31:0] got   [0:7];
    logic [31:0] exp_w;
    int k;
    int base;
    words[0] = 64'h1111_1111_AAAA_AAAA;
    words[1] = 64'h2222_2222_BBBB_BBBB;
    words[2] = 64'h3333_3333_CCCC_CCCC;
    words[3] = 64'h4444_4444_DDDD_DDDD;
    // Start from a cleared counter so the 3-bit wrap lands on 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = rdcnt1;
    if1.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push1(words[i]);
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      tick();
      if (if1.m_valid) begin
        got[k] = if1.m_data;
        k++;
      end
    end
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL b2b_count: outputs=%0d required 8", k);
    end
    for (int i = 0; i < 8; i++) begin
      exp_w = (i % 2 == 0) ? words[i/2][63:32] : words[i/2][31:0];
      tests++;
      if (i < k && got[i] !== exp_w) begin
        fails++;
        $display("FAIL b2b_data[%0d]: got %h required %h", i, got[i], exp_w);
      end
    end
    tick();
    tests++;
    if (if1.words_out !== 3'd0 || if1.m_valid !== 1'b0 || rdcnt1 - base !== 4) begin
      fails++;
      $display("FAIL b2b_done: words=%0d valid=%b pops=%0d required 0 0 4",
               if1.words_out, if1.m_valid, rdcnt1 - base);
    end
    for (int i = 1; i < 4; i++) begin
      tests++;
      if (pulse1[(base + i) % 16] - pulse1[(base + i - 1) % 16] !== 5) begin
        fails++;
        $display("FAIL b2b_gap[%0d]: gap=%0d required 5", i,
                 pulse1[(base + i) % 16] - pulse1[(base + i - 1) % 16]);
      end
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_flush();
    int n;
    int rd0;
    logic [31:0] w_before;
    // After the earlier reset, LO restarts its counter at 0.
    if0.m_ready = 1'b0;
    push0(64'h5555_6666_7777_8888);
    n = 0;
    while (!if0.m_valid && n < 20) begin tick(); n++; end
    if0.m_ready = 1'b1;
    tick();
    w_before = if0.words_out;
    tests++;
    if (w_before !== 32'd1 || if0.m_data !== 32'h5555_6666) begin
      fails++;
      $display("FAIL flush_setup: words=%0d data=%h required 1 55556666", w_before, if0.m_data);
    end
    if0.flush = 1'b1;
    tick();
    if0.flush = 1'b0;
    tests++;
    if (if0.m_valid !== 1'b0 || if0.busy !== 1'b0 || if0.words_out !== w_before) begin
      fails++;
      $display("FAIL flush_second: valid=%b busy=%b words=%0d required 0 0 %0d",
               if0.m_valid, if0.busy, if0.words_out, w_before);
    end
    push0(64'h9999_0000_1234_5678);
    n = 0;
    while (!if0.m_valid && n < 20) begin tick(); n++; end
    tests++;
    if (if0.m_valid !== 1'b1 || if0.m_data !== 32'h1234_5678) begin
      fails++;
      $display("FAIL flush_next_lo: valid=%b data=%h required 1 12345678", if0.m_valid, if0.m_data);
    end
    tick();
    tests++;
    if (if0.m_data !== 32'h9999_0000) begin
      fails++;
      $display("FAIL flush_next_hi: data=%h required 99990000", if0.m_data);
    end
    tick();
    tests++;
    if (if0.words_out !== 32'd3 || if0.m_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_next_cnt: words=%0d valid=%b required 3 0", if0.words_out, if0.m_valid);
    end

    // flush while the pop is in flight: popped word is dropped.
    rd0 = rdcnt0;
    push0(64'hBAD0_BAD0_BAD0_BAD0);
    tick();
    if0.flush = 1'b1;
    tick();
    if0.flush = 1'b0;
    tick();
    tick();
    tests++;
    if (if0.m_valid !== 1'b0 || if0.busy !== 1'b0 || rdcnt0 - rd0 !== 1 ||
        if0.words_out !== 32'd3) begin
      fails++;
      $display("FAIL flush_req: valid=%b busy=%b pops=%0d words=%0d required 0 0 1 3",
               if0.m_valid, if0.busy, rdcnt0 - rd0, if0.words_out);
    end

    // Asynchronous reset while a word sits in FIRST.
    if0.m_ready = 1'b0;
    push0(64'hFEED_FACE_0BAD_F00D);
    n = 0;
    while (!if0.m_valid && n < 20) begin tick(); n++; end
    tests++;
    if (if0.m_valid !== 1'b1 || if0.m_data !== 32'h0BAD_F00D) begin
      fails++;
      $display("FAIL arst_setup: valid=%b data=%h required 1 0badf00d", if0.m_valid, if0.m_data);
    end
    rst = 1'b1;
    #2;
    tests++;
    if (if0.m_valid !== 1'b0 || if0.m_data !== 32'h0 || if0.busy !== 1'b0 ||
        if0.words_out !== 32'h0 || if0.fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL arst_async: valid=%b data=%h busy=%b words=%0d rd_en=%b required all 0",
               if0.m_valid, if0.m_data, if0.busy, if0.words_out, if0.fifo_rd_en);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    if0.flush   = 1'b0;
    if0.m_ready = 1'b0;
    if1.flush   = 1'b0;
    if1.m_ready = 1'b0;
    test_reset();
    test_lo_first();
    test_hi_first();
    test_backpressure();
    test_back_to_back();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
